// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller.
// Forward-select codes and shadow-stage bundles.
package hazard_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     use1;
    logic     use2;
    reg_idx_t rd;
    logic     rw;
    logic     mr;
  } s_ex_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     rw;
    logic     mr;
  } s_mem_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     rw;
  } s_wb_t;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
// Counter signals exist only with HAZARD_STATS_EN.
interface hazard_forward_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              ex_branch_taken;
  logic              mem_busy;
  logic [1:0]        ForwardA;
  logic [1:0]        ForwardB;
  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_bubble;
  logic              if_id_flush;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_uses_rs1, id_uses_rs2,
    output id_rd, id_reg_write, id_mem_read,
    output ex_branch_taken, mem_busy,
    input  ForwardA, ForwardB,
    input  pc_write, if_id_write,
    input  id_ex_bubble, if_id_flush,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_uses_rs1, id_uses_rs2,
    input  id_rd, id_reg_write, id_mem_read,
    input  ex_branch_taken, mem_busy,
    output ForwardA, ForwardB,
    output pc_write, if_id_write,
    output id_ex_bubble, if_id_flush,
    output stall_cycles, flush_count
  );
`else
  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_uses_rs1, id_uses_rs2,
    output id_rd, id_reg_write, id_mem_read,
    output ex_branch_taken, mem_busy,
    input  ForwardA, ForwardB,
    input  pc_write, if_id_write,
    input  id_ex_bubble, if_id_flush
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_uses_rs1, id_uses_rs2,
    input  id_rd, id_reg_write, id_mem_read,
    input  ex_branch_taken, mem_busy,
    output ForwardA, ForwardB,
    output pc_write, if_id_write,
    output id_ex_bubble, if_id_flush
  );
`endif

endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// One forwarding-mux select: compares an EX source
// against the EX/MEM and MEM/WB shadow stages.
module fwd_select
  import hazard_pkg::*;
(
  input  logic     ex_valid,
  input  reg_idx_t src,
  input  logic     use_src,
  input  s_mem_t   s_mem,
  input  s_wb_t    s_wb,
  output logic [1:0] sel
);

  logic hit_mem;
  logic hit_wb;

  assign hit_mem = s_mem.valid & s_mem.rw
                 & (s_mem.rd != '0)
                 & (s_mem.rd == src);
  assign hit_wb  = s_wb.valid & s_wb.rw
                 & (s_wb.rd != '0)
                 & (s_wb.rd == src);

  // younger producer wins; idle or non-reading slot reads the RF
  always_comb begin
    sel = FWD_REG;
    if (ex_valid && use_src) begin
      if (hit_mem)     sel = FWD_EXMEM;
      else if (hit_wb) sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller with shadow ID/EX..MEM/WB.
// Optional statistics counters: HAZARD_STATS_EN.
module hazard_forward_ctrl
  import hazard_pkg::s_ex_t;
  import hazard_pkg::s_mem_t;
  import hazard_pkg::s_wb_t;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic clk,
  input  logic rst_n,
  hazard_forward_ctrl_if.slave hz
);

  s_ex_t  s_ex;
  s_mem_t s_mem;
  s_wb_t  s_wb;

  logic [REG_AW-1:0] ex_rd;
  logic              load_use;
  logic              flush;
  logic              busy;

  assign ex_rd = s_ex.rd;
  assign busy  = hz.mem_busy;

  assign load_use = s_ex.valid & s_ex.mr
                  & (ex_rd != '0) & hz.id_valid
                  & ((hz.id_uses_rs1 & (hz.id_rs1 == ex_rd))
                   | (hz.id_uses_rs2 & (hz.id_rs2 == ex_rd)));

  assign flush = hz.ex_branch_taken & s_ex.valid;

  fwd_select u_fwd_a (
    .ex_valid (s_ex.valid),
    .src      (s_ex.rs1),
    .use_src  (s_ex.use1),
    .s_mem    (s_mem),
    .s_wb     (s_wb),
    .sel      (hz.ForwardA)
  );

  fwd_select u_fwd_b (
    .ex_valid (s_ex.valid),
    .src      (s_ex.rs2),
    .use_src  (s_ex.use2),
    .s_mem    (s_mem),
    .s_wb     (s_wb),
    .sel      (hz.ForwardB)
  );

  // busy freezes all; a flush squashes any stalled instruction
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.if_id_write  = 1'b1;
    hz.id_ex_bubble = 1'b0;
    hz.if_id_flush  = 1'b0;
    unique case (1'b1)
      busy: begin
        hz.pc_write    = 1'b0;
        hz.if_id_write = 1'b0;
      end
      !busy && flush: begin
        hz.if_id_flush  = 1'b1;
        hz.id_ex_bubble = 1'b1;
      end
      !busy && !flush && load_use: begin
        hz.pc_write     = 1'b0;
        hz.if_id_write  = 1'b0;
        hz.id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // shadow pipeline advances with the real pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ex  <= '0;
      s_mem <= '0;
      s_wb  <= '0;
    end else if (!busy) begin
      s_wb.valid <= s_mem.valid;
      s_wb.rd    <= s_mem.rd;
      s_wb.rw    <= s_mem.rw;
      s_mem.valid <= s_ex.valid;
      s_mem.rd    <= s_ex.rd;
      s_mem.rw    <= s_ex.rw;
      s_mem.mr    <= s_ex.mr;
      s_ex.valid <= hz.id_valid & ~hz.id_ex_bubble;
      s_ex.rs1   <= hz.id_rs1;
      s_ex.rs2   <= hz.id_rs2;
      s_ex.use1  <= hz.id_uses_rs1;
      s_ex.use2  <= hz.id_uses_rs2;
      s_ex.rd    <= hz.id_rd;
      s_ex.rw    <= hz.id_reg_write;
      s_ex.mr    <= hz.id_mem_read;
    end
  end

`ifdef HAZARD_STATS_EN
  logic stall_apply;

  assign stall_apply = load_use & ~flush & ~busy;

  // free-running event counters, wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz.stall_cycles <= '0;
      hz.flush_count  <= '0;
    end else begin
      if (stall_apply)
        hz.stall_cycles <= hz.stall_cycles + 1'b1;
      if (hz.if_id_flush)
        hz.flush_count <= hz.flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl.
// Drives ID metadata, checks selects/stall/flush.
module tb_hazard_forward_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hazard_forward_ctrl_if #(.REG_AW(5), .CNT_W(32)) hif ();

  hazard_forward_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic id_set(input logic v,
                        input logic [4:0] rs1,
                        input logic u1,
                        input logic [4:0] rs2,
                        input logic u2,
                        input logic [4:0] rd,
                        input logic rw,
                        input logic mr);
    hif.id_valid     = v;
    hif.id_rs1       = rs1;
    hif.id_uses_rs1  = u1;
    hif.id_rs2       = rs2;
    hif.id_uses_rs2  = u2;
    hif.id_rd        = rd;
    hif.id_reg_write = rw;
    hif.id_mem_read  = mr;
  endtask

  task automatic idle();
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
           5'd0, 1'b0, 1'b0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input string tag,
                     input logic pc,
                     input logic ifid,
                     input logic bub,
                     input logic fl);
    chk({tag, ".pc_write"}, 32'(hif.pc_write), 32'(pc));
    chk({tag, ".if_id_write"}, 32'(hif.if_id_write),
        32'(ifid));
    chk({tag, ".bubble"}, 32'(hif.id_ex_bubble), 32'(bub));
    chk({tag, ".flush"}, 32'(hif.if_id_flush), 32'(fl));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    hif.ex_branch_taken = 1'b0;
    hif.mem_busy        = 1'b0;
    id_set(1'b1, 5'd5, 1'b1, 5'd5, 1'b1,
           5'd5, 1'b1, 1'b1);
    #3;
    chk("rst.fwdA", 32'(hif.ForwardA), 32'd0);
    chk("rst.fwdB", 32'(hif.ForwardB), 32'd0);
    ctl("rst", 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
    chk("rst.stall_cnt", hif.stall_cycles, 32'd0);
    chk("rst.flush_cnt", hif.flush_count, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // back-to-back ALU: add x5; sub x6,x5,x1; or x9,x3,x5
    adv();
    id_set(1'b1, 5'd1, 1'b1, 5'd2, 1'b1,
           5'd5, 1'b1, 1'b0);
    adv();
    id_set(1'b1, 5'd5, 1'b1, 5'd1, 1'b1,
           5'd6, 1'b1, 1'b0);
    adv();
    id_set(1'b1, 5'd3, 1'b1, 5'd5, 1'b1,
           5'd9, 1'b1, 1'b0);
    #1;
    chk("alu.fwdA_exmem", 32'(hif.ForwardA), 32'd2);
    chk("alu.fwdB_none", 32'(hif.ForwardB), 32'd0);
    adv();
    idle();
    #1;
    chk("alu.fwdB_wb", 32'(hif.ForwardB), 32'd1);
    chk("alu.fwdA_none", 32'(hif.ForwardA), 32'd0);

    // double hazard: x5 in MEM and WB; rs2=x5 not read
    id_set(1'b1, 5'd1, 1'b1, 5'd2, 1'b1,
           5'd5, 1'b1, 1'b0);
    adv();
    id_set(1'b1, 5'd3, 1'b1, 5'd4, 1'b1,
           5'd5, 1'b1, 1'b0);
    adv();
    id_set(1'b1, 5'd5, 1'b1, 5'd5, 1'b0,
           5'd10, 1'b1, 1'b0);
    adv();
    idle();
    #1;
    chk("dbl.fwdA_exmem", 32'(hif.ForwardA), 32'd2);
    chk("dbl.fwdB_unused", 32'(hif.ForwardB), 32'd0);

    // x0 destination never forwarded
    id_set(1'b1, 5'd1, 1'b1, 5'd0, 1'b0,
           5'd0, 1'b1, 1'b0);
    adv();
    id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b1,
           5'd11, 1'b1, 1'b0);
    adv();
    idle();
    #1;
    chk("x0.fwdA", 32'(hif.ForwardA), 32'd0);
    chk("x0.fwdB", 32'(hif.ForwardB), 32'd0);
    adv();
    adv();
    adv();

    // load-use: lw x7; add x8,x7,x2
    id_set(1'b1, 5'd2, 1'b1, 5'd0, 1'b0,
           5'd7, 1'b1, 1'b1);
    adv();
    id_set(1'b1, 5'd7, 1'b1, 5'd2, 1'b1,
           5'd8, 1'b1, 1'b0);
    #1;
    ctl("lu.stall", 1'b0, 1'b0, 1'b1, 1'b0);
    adv();
    #1;
    ctl("lu.held", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu.bubble_fwdA", 32'(hif.ForwardA), 32'd0);
    adv();
    idle();
    #1;
    chk("lu.fwdA_wb", 32'(hif.ForwardA), 32'd1);
    ctl("lu.after", 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
    chk("lu.stall_cnt", hif.stall_cycles, 32'd1);
`endif
    adv();
    adv();
    adv();

    // flush beats stall: lw x7 in EX, taken branch
    id_set(1'b1, 5'd2, 1'b1, 5'd0, 1'b0,
           5'd7, 1'b1, 1'b1);
    adv();
    id_set(1'b1, 5'd7, 1'b1, 5'd2, 1'b1,
           5'd8, 1'b1, 1'b0);
    hif.ex_branch_taken = 1'b1;
    #1;
    ctl("fl", 1'b1, 1'b1, 1'b1, 1'b1);
    adv();
    idle();
    #1;
    ctl("fl.squashed", 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
    chk("fl.stall_cnt", hif.stall_cycles, 32'd1);
    chk("fl.flush_cnt", hif.flush_count, 32'd1);
`endif
    hif.ex_branch_taken = 1'b0;
    adv();
    adv();
    adv();

    // mem_busy for 3 cycles with a live forward
    id_set(1'b1, 5'd1, 1'b1, 5'd2, 1'b1,
           5'd5, 1'b1, 1'b0);
    adv();
    id_set(1'b1, 5'd5, 1'b1, 5'd1, 1'b1,
           5'd6, 1'b1, 1'b0);
    adv();
    id_set(1'b1, 5'd6, 1'b1, 5'd6, 1'b1,
           5'd12, 1'b1, 1'b1);
    hif.mem_busy = 1'b1;
    hif.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("busy%0d.fwdA", i),
          32'(hif.ForwardA), 32'd2);
      chk($sformatf("busy%0d.fwdB", i),
          32'(hif.ForwardB), 32'd0);
      ctl($sformatf("busy%0d", i),
          1'b0, 1'b0, 1'b0, 1'b0);
      adv();
    end
    hif.mem_busy = 1'b0;
    hif.ex_branch_taken = 1'b0;
    #1;
    chk("busy.post_fwdA", 32'(hif.ForwardA), 32'd2);
    ctl("busy.post", 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
    chk("busy.flush_cnt", hif.flush_count, 32'd1);
`endif

    // async reset pulse while ID would stall/forward
    @(negedge clk);
    hif.ex_branch_taken = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("rst2.fwdA", 32'(hif.ForwardA), 32'd0);
    chk("rst2.fwdB", 32'(hif.ForwardB), 32'd0);
    ctl("rst2", 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
    chk("rst2.stall_cnt", hif.stall_cycles, 32'd0);
    chk("rst2.flush_cnt", hif.flush_count, 32'd0);
`endif
    @(negedge clk);
    hif.ex_branch_taken = 1'b0;
    idle();
    rst_n = 1'b1;
    adv();
    #1;
    ctl("rel", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
